// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin quantum arbiter.
package arb_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping to index 0.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // First pass covers ptr..N-1, second pass wraps around from 0.
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_quantum_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant and optional
// quantum-based preemption (enabled by defining ARB_QUANTUM_EN).
module rr_quantum_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 3,
  parameter int QUANTUM = 8,
  parameter int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  r,
  output logic [N-1:0]  g,
  output logic          busy,
  output logic [IW-1:0] owner,
  output logic          preempt
);

  if (N < 2 || N > MAX_N || QUANTUM < 1) begin : g_param_err
    $error("rr_quantum_arbiter: need 2 <= N <= MAX_N and QUANTUM >= 1");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          expire;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (r),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef ARB_QUANTUM_EN
  localparam int            CW   = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] QMAX = CW'(QUANTUM);

  logic [CW-1:0]    cnt_q;
  logic [MAX_N-1:0] others;
  logic             preempt_q;

  assign others = MAX_N'(r) & ~onehot(32'(owner_q));
  assign expire = (cnt_q == QMAX) && (|others);

  // Hold counter: loaded to 1 on grant, saturates at QUANTUM.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (pick_valid) cnt_q <= CW'(1);
    end else if (cnt_q != QMAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Release by the owner takes precedence over a forced release.
  always_ff @(posedge clk) begin
    if (reset) preempt_q <= 1'b0;
    else       preempt_q <= (state_q == ARB_GRANT) && r[owner_q] && expire;
  end

  assign preempt = preempt_q;
`else
  assign expire  = 1'b0;
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      ARB_GRANT: begin
        if (!r[owner_q] || expire) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy  = (state_q == ARB_GRANT);
  assign owner = owner_q;
  assign g     = busy ? N'(onehot(32'(owner_q))) : '0;

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Directed and randomized bench for rr_quantum_arbiter against a behavioural
// round-robin/quantum model; follows ARB_QUANTUM_EN like the design.
module tb_rr_quantum_arbiter;

  localparam int N  = 3;
  localparam int Q  = 8;
  localparam int IW = $clog2(N);
`ifdef ARB_QUANTUM_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [N-1:0]  r;
  logic [N-1:0]  g;
  logic          busy;
  logic [IW-1:0] owner;
  logic          preempt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_pre;

  rr_quantum_arbiter #(.N(N), .QUANTUM(Q), .IW(IW)) dut (
    .clk     (clk),
    .reset   (reset),
    .r       (r),
    .g       (g),
    .busy    (busy),
    .owner   (owner),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] rv, input bit rst);
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (rv[i]) begin
            m_busy = 1'b1; m_owner = i; m_ptr = (i + 1) % N; m_held = 1;
            break;
          end
        end
      end else if (!rv[m_owner]) begin
        m_busy = 1'b0;
      end else if (QEN && m_held >= Q && ((32'(rv) & ~(32'd1 << m_owner)) != 0)) begin
        m_busy = 1'b0; m_pre = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] rv, input bit rst);
    r     = rv;
    reset = rst;
    @(posedge clk);
    model_edge(rv, rst);
    #1;
    chk("g",       32'(g),       m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("busy",    32'(busy),    32'(m_busy));
    chk("preempt", 32'(preempt), 32'(m_pre));
    chk("owner",   32'(owner),   32'(m_owner));
  endtask

  initial begin
    logic [N-1:0] rr;
    bit           rs;
    reset = 1'b1;
    r     = '0;

    // Reset and idle hold
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);
    for (int c = 0; c < 10; c++) step(3'b000, 1'b0);
    chk("idle_g", 32'(g), 32'd0);

    // All requesting: preemption sequence from a fresh reset
    step(3'b000, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      step(3'b111, 1'b0);
      if (c <= 8) chk("pre_first_g", 32'(g), 32'b001);
      if (QEN && c == 9) begin
        chk("pre_gap_g", 32'(g), 32'd0);
        chk("pre_pulse", 32'(preempt), 32'd1);
      end
      if (QEN && c >= 10 && c <= 17) chk("pre_second_g", 32'(g), 32'b010);
    end
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);

    // Lone requester keeps the grant
    for (int c = 0; c < 20; c++) begin
      step(3'b100, 1'b0);
      if (c >= 1) chk("lone_g", 32'(g), 32'b100);
    end
    step(3'b000, 1'b0);

    // Early release hands over after one idle cycle
    step(3'b000, 1'b1);
    step(3'b011, 1'b0);
    step(3'b011, 1'b0);
    chk("early_g0", 32'(g), 32'b001);
    step(3'b010, 1'b0);
    chk("early_gap", 32'(g), 32'd0);
    step(3'b010, 1'b0);
    chk("early_g1", 32'(g), 32'b010);
    step(3'b000, 1'b0);

    // Pointer wraps from owner 2 back to index 0
    step(3'b000, 1'b1);
    step(3'b100, 1'b0);
    step(3'b000, 1'b0);
    step(3'b011, 1'b0);
    chk("wrap_g", 32'(g), 32'b001);
    chk("wrap_owner", 32'(owner), 32'd0);

    // Reset mid-grant, then priority restarts at index 0
    step(3'b000, 1'b1);
    step(3'b010, 1'b0);
    chk("rstmid_pre", 32'(g), 32'b010);
    step(3'b010, 1'b1);
    chk("rstmid_g", 32'(g), 32'd0);
    step(3'b110, 1'b0);
    chk("rstmid_after", 32'(g), 32'b010);

    // Long all-request hold (no preemption when the quantum is disabled)
    step(3'b000, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      step(3'b111, 1'b0);
      if (!QEN) chk("noq_g", 32'(g), 32'b001);
    end

    // Randomized traffic with sticky requests and occasional reset
    rr = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) rr[b] = ~rr[b];
      rs = ($urandom_range(63) == 0);
      step(rr, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_quantum_arbiter.md
# rr_quantum_arbiter

Round-robin arbiter that shares one resource among N requesters, extending the 3-way fixed-priority grant FSM with fairness and bounded hold time. It sits between requester agents and the shared resource. It issues a registered one-hot grant, rotates priority after every grant, and can forcibly reclaim the resource after a programmable quantum when other requesters are waiting.

## Interface
- N, default 3: number of requesters, at least 2.
- QUANTUM, default 8: maximum grant cycles before preemption, at least 1.
- IW, default $clog2(N): width of the owner index.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset. Single clock domain.
- r  in  N  request vector; r[i] is held high while requester i wants the resource.
- g  out  N  grant vector, registered; one-hot or all-zero.
- busy  out  1  high when any g bit is high.
- owner  out  IW  index of the granted requester; valid only when busy=1, holds its last value otherwise.
- preempt  out  1  one-cycle pulse, registered; high in the cycle after a forced release.

## Operation
- States: ARB_IDLE and ARB_GRANT. g, busy and owner are decoded from registered state and owner.
- ptr (IW bits) is the highest-priority index. Search order is ptr, ptr+1, …, wrapping modulo N.
- ARB_IDLE:
  - If r is non-zero, select the first set bit in search order, load owner, set ptr = (owner+1) mod N, load hold count = 1, and go to ARB_GRANT.
  - Otherwise stay in ARB_IDLE.
- ARB_GRANT, evaluated in this priority order:
  - r[owner]=0: go to ARB_IDLE (normal release); preempt stays 0.
  - Else, if count==QUANTUM and (r & ~onehot(owner)) is non-zero: go to ARB_IDLE and set preempt=1 for one cycle.
  - Else stay in ARB_GRANT; count increments and saturates at QUANTUM.
- Normal release and quantum expiry in the same cycle: release wins and preempt=0.
- A lone requester is never preempted. It keeps the grant indefinitely with count saturated.
- Requests that rise or fall during ARB_IDLE are sampled only at the next edge. No request is latched.
- Reset values: state=ARB_IDLE, g=0, busy=0, owner=0, preempt=0, ptr=0, count=0.
- Reset during ARB_GRANT drops g at the reset edge. After reset, index 0 has priority.

## Timing
- Grant latency: r sampled at edge t drives g at edge t (visible in cycle t+1).
- Release: r[owner] low at edge t drives g=0 at edge t.
- Every grant is followed by at least one all-zero g cycle, so no back-to-back handoff.
- A grant lasts at most QUANTUM cycles while others are waiting.
- Worst-case wait for a continuously asserted request is (N-1)*(QUANTUM+1)+1 cycles.

## Configuration
- ARB_QUANTUM_EN defined:
  - Hold counter and preemption are present as described above.
- ARB_QUANTUM_EN undefined:
  - Counter logic is removed; grants are held until r[owner] drops.
  - preempt is tied to 0.
  - QUANTUM is ignored.
  - Round-robin rotation still applies.

## Structure
- Package arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_GRANT}.
  - Function onehot(idx).
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req[N-1:0], ptr.
  - Outputs: idx[IW-1:0], valid.
  - Instantiated once in the parent.
- Parent holds the state, owner, ptr and count registers.

## Test plan
All scenarios use N=3, QUANTUM=8 and ARB_QUANTUM_EN defined unless noted.
- Idle hold: reset, then r=000 for 10 cycles -> g=000, busy=0, preempt=0 throughout.
- Preemption: r=111 from cycle 0 -> g=001 cycles 1–8; g=000 with preempt=1 in cycle 9; g=010 cycles 10–17; then g=100.
- Lone requester: r=100 held 20 cycles -> g=100 from cycle 1 onward with no gap; preempt never asserts.
- Early release: grant to 0 with r=011; drop r[0] in cycle 3 -> g=000 in cycle 4, g=010 in cycle 5, preempt=0.
- Pointer wrap: owner 2 releases, then r=011 -> g=001; owner=0.
- Reset mid-grant and macro off:
  - Assert reset while g=010 -> g=000 next cycle.
  - Then r=110 -> g=010.
  - With ARB_QUANTUM_EN undefined and r=111 held 30 cycles -> g=001 throughout, preempt=0.
